// File: rtl/ex_mem_stage_if.sv
// EX-to-MEM stage bus: EX-side handshake and payload, MEM-side handshake and payload,
// flush and branch redirect.
interface ex_mem_stage_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned REG_W  = 5
);
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_result;
    logic              in_equal;
    logic [DATA_W-1:0] in_store_data;
    logic [REG_W-1:0]  in_rd;
    logic              in_reg_write;
    logic              in_mem_read;
    logic              in_mem_write;
    logic              in_branch;
    logic              in_branch_ne;
    logic [DATA_W-1:0] in_target;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_result;
    logic [DATA_W-1:0] out_store_data;
    logic [REG_W-1:0]  out_rd;
    logic              out_reg_write;
    logic              out_mem_read;
    logic              out_mem_write;
    logic              redirect;
    logic [DATA_W-1:0] redirect_pc;

    modport master (
        output flush, in_valid, in_result, in_equal, in_store_data, in_rd, in_reg_write,
               in_mem_read, in_mem_write, in_branch, in_branch_ne, in_target, out_ready,
        input  in_ready, out_valid, out_result, out_store_data, out_rd, out_reg_write,
               out_mem_read, out_mem_write, redirect, redirect_pc
    );

    modport slave (
        input  flush, in_valid, in_result, in_equal, in_store_data, in_rd, in_reg_write,
               in_mem_read, in_mem_write, in_branch, in_branch_ne, in_target, out_ready,
        output in_ready, out_valid, out_result, out_store_data, out_rd, out_reg_write,
               out_mem_read, out_mem_write, redirect, redirect_pc
    );
endinterface

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register with a two-entry skid buffer and BEQ/BNE resolution.
// in_ready is a flop output, so MEM backpressure never reaches EX combinationally.
module ex_mem_stage #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned REG_W  = 5
) (
    input logic           clk,
    input logic           reset,
    ex_mem_stage_if.slave bus
);
    typedef struct packed {
        logic [DATA_W-1:0] result;
        logic [DATA_W-1:0] store_data;
        logic [REG_W-1:0]  rd;
        logic              reg_write;
        logic              mem_read;
        logic              mem_write;
    } entry_t;

    // Encoding is {out_valid, skid_valid}; 2'b01 is unreachable.
    typedef enum logic [1:0] {
        StEmpty = 2'b00,
        StOne   = 2'b10,
        StFull  = 2'b11
    } state_e;

    state_e            state_q, state_d;
    entry_t            main_q, main_d;
    entry_t            skid_q, skid_d;
    entry_t            in_entry;
    logic              redirect_q, redirect_d;
    logic [DATA_W-1:0] redirect_pc_q, redirect_pc_d;
    logic              in_ready;
    logic              accept;
    logic              deliver;
    logic              taken;

    assign in_ready = ~state_q[0];
    assign accept   = bus.in_valid & in_ready & ~bus.flush;
    assign deliver  = state_q[1] & bus.out_ready;
    assign taken    = bus.in_branch & (bus.in_equal ^ bus.in_branch_ne);

    always_comb begin
        in_entry            = '0;
        in_entry.result     = bus.in_result;
        in_entry.store_data = bus.in_store_data;
        in_entry.rd         = bus.in_rd;
        in_entry.reg_write  = bus.in_reg_write;
        in_entry.mem_read   = bus.in_mem_read;
        in_entry.mem_write  = bus.in_mem_write;
    end

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        case (state_q)
            StEmpty: begin
                if (accept) begin
                    main_d  = in_entry;
                    state_d = StOne;
                end
            end
            StOne: begin
                if (accept && deliver) begin
                    main_d = in_entry;
                end else if (accept) begin
                    skid_d  = in_entry;
                    state_d = StFull;
                end else if (deliver) begin
                    state_d = StEmpty;
                end
            end
            StFull: begin
                if (deliver) begin
                    main_d  = skid_q;
                    skid_d  = '0;
                    state_d = StOne;
                end
            end
            default: state_d = StEmpty;
        endcase
        if (bus.flush) begin
            state_d = StEmpty;
        end
    end

    // Redirect is decided at accept, so a flushed input never produces a pulse.
    always_comb begin
        redirect_d    = accept & taken;
        redirect_pc_d = redirect_pc_q;
        if (accept && taken) begin
            redirect_pc_d = bus.in_target;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= StEmpty;
            main_q        <= '0;
            skid_q        <= '0;
            redirect_q    <= 1'b0;
            redirect_pc_q <= '0;
        end else begin
            state_q       <= state_d;
            main_q        <= main_d;
            skid_q        <= skid_d;
            redirect_q    <= redirect_d;
            redirect_pc_q <= redirect_pc_d;
        end
    end

    assign bus.in_ready       = in_ready;
    assign bus.out_valid      = state_q[1];
    assign bus.out_result     = main_q.result;
    assign bus.out_store_data = main_q.store_data;
    assign bus.out_rd         = main_q.rd;
    assign bus.out_reg_write  = main_q.reg_write;
    assign bus.out_mem_read   = main_q.mem_read;
    assign bus.out_mem_write  = main_q.mem_write;
    assign bus.redirect       = redirect_q;
    assign bus.redirect_pc    = redirect_pc_q;
endmodule

// File: tb/tb_ex_mem_stage.sv
// Bench for ex_mem_stage: directed scenarios plus a randomised run checked against a
// queue-based model of a two-deep FIFO with branch redirect.
module tb_ex_mem_stage;
    typedef struct packed {
        logic [31:0] result;
        logic [31:0] store_data;
        logic [4:0]  rd;
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int unsigned checks = 0;
    int unsigned passes = 0;

    always #5 clk = ~clk;

    ex_mem_stage_if #(.DATA_W(32), .REG_W(5)) bus ();

    ex_mem_stage #(.DATA_W(32), .REG_W(5)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.flush         = 1'b0;
        bus.in_valid      = 1'b0;
        bus.in_result     = 32'h0;
        bus.in_equal      = 1'b0;
        bus.in_store_data = 32'h0;
        bus.in_rd         = 5'h0;
        bus.in_reg_write  = 1'b0;
        bus.in_mem_read   = 1'b0;
        bus.in_mem_write  = 1'b0;
        bus.in_branch     = 1'b0;
        bus.in_branch_ne  = 1'b0;
        bus.in_target     = 32'h0;
        bus.out_ready     = 1'b0;
    endtask

    task automatic offer(input logic [31:0] res);
        bus.in_valid      = 1'b1;
        bus.in_result     = res;
        bus.in_store_data = ~res;
        bus.in_rd         = res[4:0];
        bus.in_reg_write  = 1'b1;
        bus.in_mem_read   = res[0];
        bus.in_mem_write  = res[1];
        bus.in_branch     = 1'b0;
        bus.in_branch_ne  = 1'b0;
        bus.in_equal      = 1'b0;
    endtask

    task automatic offer_branch(input logic ne, input logic eq, input logic [31:0] tgt);
        bus.in_valid      = 1'b1;
        bus.in_result     = tgt;
        bus.in_store_data = 32'h0;
        bus.in_rd         = 5'h0;
        bus.in_reg_write  = 1'b0;
        bus.in_mem_read   = 1'b0;
        bus.in_mem_write  = 1'b0;
        bus.in_branch     = 1'b1;
        bus.in_branch_ne  = ne;
        bus.in_equal      = eq;
        bus.in_target     = tgt;
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        idle();
        reset = 1'b1;
        repeat (2) tick();
        checks++;
        if ({bus.out_valid, bus.in_ready, bus.redirect} !== 3'b010) begin
            $display("FAIL reset_ctrl: got {out_valid,in_ready,redirect}=%b want 010",
                     {bus.out_valid, bus.in_ready, bus.redirect});
        end else passes++;
        checks++;
        if ({bus.out_result, bus.out_store_data, bus.out_rd, bus.out_reg_write,
             bus.out_mem_read, bus.out_mem_write, bus.redirect_pc} !== 104'h0) begin
            $display("FAIL reset_data: got result=%h store=%h rd=%h pc=%h want all 0",
                     bus.out_result, bus.out_store_data, bus.out_rd, bus.redirect_pc);
        end else passes++;
        reset = 1'b0;
    endtask

    task automatic test_streaming();
        do_reset();
        bus.out_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            offer(32'(i));
            tick();
            checks++;
            if (bus.out_valid !== 1'b1 || bus.out_result !== 32'(i) || bus.in_ready !== 1'b1)
            begin
                $display("FAIL stream_%0d: got valid=%b result=%h in_ready=%b want 1 %h 1",
                         i, bus.out_valid, bus.out_result, bus.in_ready, 32'(i));
            end else passes++;
        end
        bus.in_valid = 1'b0;
        tick();
        checks++;
        if (bus.out_valid !== 1'b0) begin
            $display("FAIL stream_drain: got out_valid=%b want 0", bus.out_valid);
        end else passes++;
    endtask

    task automatic test_backpressure();
        do_reset();
        bus.out_ready = 1'b0;
        offer(32'hA);
        tick();
        offer(32'hB);
        tick();
        checks++;
        if (bus.in_ready !== 1'b0 || bus.out_result !== 32'hA) begin
            $display("FAIL bp_full: got in_ready=%b result=%h want 0 0000000a",
                     bus.in_ready, bus.out_result);
        end else passes++;
        offer(32'hC);
        tick();
        checks++;
        if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1 || bus.out_result !== 32'hA ||
            bus.out_store_data !== ~32'hA || bus.out_mem_write !== 1'b1) begin
            $display("FAIL bp_hold: got in_ready=%b valid=%b result=%h store=%h mw=%b",
                     bus.in_ready, bus.out_valid, bus.out_result, bus.out_store_data,
                     bus.out_mem_write);
        end else passes++;
        bus.out_ready = 1'b1;
        tick();
        checks++;
        if (bus.out_result !== 32'hB || bus.out_rd !== 5'hB || bus.in_ready !== 1'b1) begin
            $display("FAIL bp_second: got result=%h rd=%h in_ready=%b want 0000000b 0b 1",
                     bus.out_result, bus.out_rd, bus.in_ready);
        end else passes++;
        tick();
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_result !== 32'hC) begin
            $display("FAIL bp_third: got valid=%b result=%h want 1 0000000c",
                     bus.out_valid, bus.out_result);
        end else passes++;
        bus.in_valid = 1'b0;
        tick();
        checks++;
        if (bus.out_valid !== 1'b0) begin
            $display("FAIL bp_drain: got out_valid=%b want 0", bus.out_valid);
        end else passes++;
    endtask

    task automatic test_branch();
        do_reset();
        bus.out_ready = 1'b1;
        offer_branch(1'b0, 1'b1, 32'h40);
        tick();
        checks++;
        if (bus.redirect !== 1'b1 || bus.redirect_pc !== 32'h40 || bus.out_reg_write !== 1'b0)
        begin
            $display("FAIL beq_taken: got redirect=%b pc=%h rw=%b want 1 00000040 0",
                     bus.redirect, bus.redirect_pc, bus.out_reg_write);
        end else passes++;
        idle();
        bus.out_ready = 1'b1;
        tick();
        checks++;
        if (bus.redirect !== 1'b0 || bus.redirect_pc !== 32'h40) begin
            $display("FAIL beq_one_cycle: got redirect=%b pc=%h want 0 00000040",
                     bus.redirect, bus.redirect_pc);
        end else passes++;
        offer_branch(1'b1, 1'b1, 32'h80);
        tick();
        checks++;
        if (bus.redirect !== 1'b0 || bus.redirect_pc !== 32'h40) begin
            $display("FAIL bne_not_taken: got redirect=%b pc=%h want 0 00000040",
                     bus.redirect, bus.redirect_pc);
        end else passes++;
        offer_branch(1'b1, 1'b0, 32'h84);
        tick();
        checks++;
        if (bus.redirect !== 1'b1 || bus.redirect_pc !== 32'h84) begin
            $display("FAIL bne_taken: got redirect=%b pc=%h want 1 00000084",
                     bus.redirect, bus.redirect_pc);
        end else passes++;
        offer_branch(1'b0, 1'b0, 32'h88);
        tick();
        checks++;
        if (bus.redirect !== 1'b0 || bus.redirect_pc !== 32'h84) begin
            $display("FAIL beq_not_taken: got redirect=%b pc=%h want 0 00000084",
                     bus.redirect, bus.redirect_pc);
        end else passes++;
    endtask

    task automatic test_flush();
        do_reset();
        offer(32'h1);
        tick();
        offer(32'h2);
        tick();
        offer_branch(1'b0, 1'b1, 32'h100);
        bus.flush = 1'b1;
        tick();
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.redirect !== 1'b0) begin
            $display("FAIL flush_full: got valid=%b in_ready=%b redirect=%b want 0 1 0",
                     bus.out_valid, bus.in_ready, bus.redirect);
        end else passes++;
        tick();
        checks++;
        if (bus.out_valid !== 1'b0 || bus.redirect !== 1'b0 || bus.redirect_pc !== 32'h0) begin
            $display("FAIL flush_empty: got valid=%b redirect=%b pc=%h want 0 0 00000000",
                     bus.out_valid, bus.redirect, bus.redirect_pc);
        end else passes++;
        bus.flush = 1'b0;
        offer_branch(1'b0, 1'b1, 32'h200);
        tick();
        bus.in_valid  = 1'b0;
        bus.flush     = 1'b1;
        bus.out_ready = 1'b1;
        checks++;
        if (bus.redirect !== 1'b1 || bus.out_valid !== 1'b1) begin
            $display("FAIL flush_prior_redirect: got redirect=%b valid=%b want 1 1",
                     bus.redirect, bus.out_valid);
        end else passes++;
        tick();
        checks++;
        if (bus.out_valid !== 1'b0 || bus.redirect !== 1'b0 || bus.redirect_pc !== 32'h200) begin
            $display("FAIL flush_deliver: got valid=%b redirect=%b pc=%h want 0 0 00000200",
                     bus.out_valid, bus.redirect, bus.redirect_pc);
        end else passes++;
        idle();
    endtask

    task automatic test_async_reset();
        do_reset();
        offer(32'h11);
        tick();
        offer_branch(1'b0, 1'b1, 32'h300);
        tick();
        idle();
        checks++;
        if (bus.in_ready !== 1'b0 || bus.redirect !== 1'b1) begin
            $display("FAIL areset_setup: got in_ready=%b redirect=%b want 0 1",
                     bus.in_ready, bus.redirect);
        end else passes++;
        #2 reset = 1'b1;
        #1;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.redirect !== 1'b0 || bus.in_ready !== 1'b1 ||
            bus.out_result !== 32'h0) begin
            $display("FAIL areset_now: got valid=%b redirect=%b in_ready=%b result=%h",
                     bus.out_valid, bus.redirect, bus.in_ready, bus.out_result);
        end else passes++;
        #1 reset = 1'b0;
        tick();
        checks++;
        if (bus.out_valid !== 1'b0 || bus.redirect !== 1'b0) begin
            $display("FAIL areset_after: got valid=%b redirect=%b want 0 0",
                     bus.out_valid, bus.redirect);
        end else passes++;
    endtask

    task automatic test_random();
        exp_t        mq[$];
        exp_t        e;
        exp_t        obs;
        int unsigned accepted = 0;
        int unsigned cycles   = 0;
        logic        exp_redir = 1'b0;
        logic [31:0] exp_pc    = 32'h0;
        logic        acc;
        logic        del;
        logic        tk;
        do_reset();
        while ((accepted < 1000 || mq.size() > 0) && cycles < 20000) begin
            obs.result     = bus.out_result;
            obs.store_data = bus.out_store_data;
            obs.rd         = bus.out_rd;
            obs.reg_write  = bus.out_reg_write;
            obs.mem_read   = bus.out_mem_read;
            obs.mem_write  = bus.out_mem_write;
            checks++;
            if (bus.out_valid !== (mq.size() > 0) || bus.in_ready !== (mq.size() < 2)) begin
                $display("FAIL rnd_hs cyc %0d: got valid=%b in_ready=%b, model holds %0d",
                         cycles, bus.out_valid, bus.in_ready, mq.size());
            end else passes++;
            if (mq.size() > 0) begin
                checks++;
                if (obs !== mq[0]) begin
                    $display("FAIL rnd_payload cyc %0d: got %h want %h", cycles, obs, mq[0]);
                end else passes++;
            end
            checks++;
            if (bus.redirect !== exp_redir || bus.redirect_pc !== exp_pc) begin
                $display("FAIL rnd_redirect cyc %0d: got %b/%h want %b/%h", cycles,
                         bus.redirect, bus.redirect_pc, exp_redir, exp_pc);
            end else passes++;

            if (accepted < 1000) begin
                bus.in_valid  = ($urandom_range(0, 9) < 7);
                bus.out_ready = ($urandom_range(0, 9) < 6);
                bus.flush     = ($urandom_range(0, 63) == 0);
            end else begin
                bus.in_valid  = 1'b0;
                bus.out_ready = 1'b1;
                bus.flush     = 1'b0;
            end
            bus.in_result     = $urandom;
            bus.in_store_data = $urandom;
            bus.in_rd         = 5'($urandom_range(0, 31));
            bus.in_reg_write  = 1'($urandom_range(0, 1));
            bus.in_mem_read   = 1'($urandom_range(0, 1));
            bus.in_mem_write  = 1'($urandom_range(0, 1));
            bus.in_branch     = 1'($urandom_range(0, 1));
            bus.in_branch_ne  = 1'($urandom_range(0, 1));
            bus.in_equal      = 1'($urandom_range(0, 1));
            bus.in_target     = $urandom;

            e.result     = bus.in_result;
            e.store_data = bus.in_store_data;
            e.rd         = bus.in_rd;
            e.reg_write  = bus.in_reg_write;
            e.mem_read   = bus.in_mem_read;
            e.mem_write  = bus.in_mem_write;
            acc = bus.in_valid && (mq.size() < 2) && !bus.flush;
            del = bus.out_ready && (mq.size() > 0);
            tk  = bus.in_branch && (bus.in_equal != bus.in_branch_ne);
            if (del) void'(mq.pop_front());
            if (acc) begin
                mq.push_back(e);
                accepted++;
            end
            if (bus.flush) mq.delete();
            exp_redir = acc && tk;
            if (exp_redir) exp_pc = bus.in_target;
            tick();
            cycles++;
        end
        checks++;
        if (accepted < 1000 || mq.size() != 0) begin
            $display("FAIL rnd_budget: accepted %0d of 1000, %0d left after %0d cycles",
                     accepted, mq.size(), cycles);
        end else passes++;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.redirect !== exp_redir) begin
            $display("FAIL rnd_final: got valid=%b redirect=%b want 0 %b",
                     bus.out_valid, bus.redirect, exp_redir);
        end else passes++;
        idle();
    endtask

    initial begin
        idle();
        reset = 1'b0;
        test_reset();
        test_streaming();
        test_backpressure();
        test_branch();
        test_flush();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
